reg_bank_loader: RTL and testbench
==================================

Name: reg_bank_loader

Overview:
- Sequencer that sits directly upstream of the single-cycle processor top level.
- Loads initial register-bank contents from a valid/ready word stream by driving the top's `escribir`/`dirIniciar`/`EWIniciar` init port.
- Then releases the core by raising `sel` for a bounded or unbounded run window.
- Gives benches and board wrappers one deterministic load-then-run control point.

Parameters:
- FIRST_REG, 1: first register address written; register 0 is skipped by default.
- LAST_REG, 31: last register address written; must be ≥ FIRST_REG and ≤ 31.
- RUN_CYCLES, 16'd0: length of the run window in clk cycles; 0 = run until `stop`.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin load sequence; sampled only in IDLE.
- stop  input  1  abort load or run; returns to IDLE next edge.
- in_valid  input  1  in_data holds a register word.
- in_data  input  32  word for the current register address.
- in_ready  output  1  loader accepts a word this cycle.
- escribir  output  32  register write data to the core init port.
- dirIniciar  output  5  register write address to the core init port.
- EWIniciar  output  1  register write enable to the core init port.
- sel  output  1  1 = core owns the register-bank write port (run); 0 = loader owns it.
- busy  output  1  high in LOAD or RUN.
- done  output  1  one-cycle pulse at normal end of RUN.
- cyc_count  output  16  cycles elapsed in the current RUN, saturating at 16'hFFFF.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: escribir=0, dirIniciar=0, EWIniciar=0, sel=0, in_ready=0, busy=0, done=0, cyc_count=0, state=IDLE, addr counter=FIRST_REG.
- rst in any state wins over every other input, including an in-flight transfer. An accepted-but-unwritten word is dropped; EWIniciar is 0 on the following cycle.
- States: IDLE, LOAD, RUN.
- IDLE:
  - in_ready=0, sel=0.
  - start=1 → LOAD next edge; addr counter=FIRST_REG.
  - stop in IDLE is ignored.
- LOAD:
  - in_ready=1, combinationally equal to (state==LOAD).
  - Transfer occurs when in_valid && in_ready.
  - On transfer at edge N: escribir<=in_data, dirIniciar<=addr, EWIniciar<=1. These are visible during cycle N+1, so the write has 1-cycle latency.
  - EWIniciar is 1 for exactly one cycle per transfer. Back-to-back transfers give consecutive EWIniciar pulses with a new address each cycle.
  - escribir and dirIniciar hold their last values when no transfer occurs.
  - Transfer with addr==LAST_REG → RUN next edge, with the write for LAST_REG still issued.
  - in_valid=0 stalls indefinitely with no timeout.
- LOAD→RUN: sel rises on the edge after the last word's EWIniciar pulse. EWIniciar and sel are never both 1 in the same cycle.
- RUN:
  - sel=1, in_ready=0, EWIniciar=0.
  - cyc_count resets to 0 on entry and increments each cycle, saturating.
  - If RUN_CYCLES≠0 and cyc_count==RUN_CYCLES-1 → IDLE next edge, with done=1 for that single following cycle and sel=0.
  - If RUN_CYCLES==0, RUN persists until stop.
- stop=1 in LOAD or RUN → IDLE next edge; sel=0 and in_ready=0; no done pulse.
- Simultaneous stop and transfer in LOAD: stop wins; the word is not written (EWIniciar stays 0).
- Simultaneous stop with the final RUN cycle: stop wins; no done pulse.
- start while busy is ignored.
- cyc_count holds its value after RUN ends until the next RUN entry or rst.

Decomposition:
- Shared package (procesador_pkg):
  - State encoding: IDLE=2'd0, LOAD=2'd1, RUN=2'd2.
  - REG_ADDR_W=5, DATA_W=32.
  - RUN_CNT_W=16.
- One natural sub-module: sat_counter, a width-parameterised saturating counter with sync clear. Used for cyc_count.
- Address counter and FSM stay inline.

Test Plan:
- Reset mid-LOAD: after 3 transfers, assert rst 1 cycle → all outputs 0 next cycle; restart loads from address 1 again.
- Full load, RUN_CYCLES=5:
  - Stimulus: start, then 31 back-to-back words 32'h100+addr.
  - Required: EWIniciar high 31 consecutive cycles; dirIniciar 1..31 in order; escribir 32'h101..32'h11F.
  - Required: sel rises on the cycle after the final write and stays high exactly 5 cycles; done pulses 1 cycle; sel=0 after.
- Stall handling: in_valid toggled 1,0,0,1 with words A5A5A5A5, 5A5A5A5A → exactly 2 EWIniciar pulses, at addresses 1 and 2, each 1 cycle after its transfer.
- Stop during RUN, RUN_CYCLES=0: stop at cyc_count=7 → IDLE next edge; sel=0; done stays 0; cyc_count holds 7.
- Stop coincident with transfer at address 4 → no EWIniciar pulse for address 4; state IDLE; in_ready=0.
- Start ignored while busy, and FIRST_REG=LAST_REG=8: start pulses during RUN have no effect; a single word loads only address 8, then RUN is entered.

Source files
------------

// File: rtl/procesador_pkg.sv
// Shared types and widths for the register-bank loader and its helpers.
package procesador_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int RUN_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } loader_state_e;

endpackage

// File: rtl/reg_bank_loader_sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones, with a synchronous clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear has priority; otherwise count up while enabled until the value saturates.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/reg_bank_loader.sv
// Load-then-run sequencer: streams words into the core's register bank through
// the init port, then hands the write port to the core for a run window.
module reg_bank_loader
  import procesador_pkg::*;
#(
  parameter int unsigned          FIRST_REG  = 1,
  parameter int unsigned          LAST_REG   = 31,
  parameter logic [RUN_CNT_W-1:0] RUN_CYCLES = 16'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic [DATA_W-1:0]     escribir,
  output logic [REG_ADDR_W-1:0] dirIniciar,
  output logic                  EWIniciar,
  output logic                  sel,
  output logic                  busy,
  output logic                  done,
  output logic [RUN_CNT_W-1:0]  cyc_count
);

  localparam logic [REG_ADDR_W-1:0] FIRST_ADDR   = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_ADDR    = REG_ADDR_W'(LAST_REG);
  localparam logic [RUN_CNT_W-1:0]  LAST_RUN_CYC = RUN_CYCLES - RUN_CNT_W'(1);

  loader_state_e         state_q, state_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     escribir_q, escribir_d;
  logic [REG_ADDR_W-1:0] dir_q, dir_d;
  logic                  ew_q, ew_d;
  logic                  done_q, done_d;

  logic wrEn;
  logic lastWrite;
  logic runLive;
  logic runEnd;
  logic cntClear;
  logic cntEn;

  // A word is written only if it is accepted in LOAD and not cancelled by stop.
  // The first RUN cycle still carries the last write pulse, so the core only
  // owns the bank (and the window only starts) once that pulse has gone.
  assign wrEn      = in_valid && (state_q == LOAD) && !stop;
  assign lastWrite = wrEn && (addr_q == LAST_ADDR);
  assign runLive   = (state_q == RUN) && !ew_q;
  assign runEnd    = runLive && !stop && (RUN_CYCLES != '0) && (cyc_count == LAST_RUN_CYC);
  assign cntClear  = (state_q != RUN) && (state_d == RUN);
  assign cntEn     = runLive && (state_d == RUN);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: stop wins over everything except reset; start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (lastWrite) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop || runEnd) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_ready = 1'b0;
    sel      = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      RUN: begin
        sel  = !ew_q;
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Next values for the address counter, the init-port registers and the done pulse.
  always_comb begin
    addr_d     = addr_q;
    escribir_d = escribir_q;
    dir_d      = dir_q;
    ew_d       = wrEn;
    done_d     = runEnd;
    if ((state_q == IDLE) && start) begin
      addr_d = FIRST_ADDR;
    end else if (wrEn && !lastWrite) begin
      addr_d = addr_q + 1'b1;
    end
    if (wrEn) begin
      escribir_d = in_data;
      dir_d      = addr_q;
    end
  end

  // Datapath registers; the init port is registered so each write lands one cycle after its transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= FIRST_ADDR;
      escribir_q <= '0;
      dir_q      <= '0;
      ew_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      escribir_q <= escribir_d;
      dir_q      <= dir_d;
      ew_q       <= ew_d;
      done_q     <= done_d;
    end
  end

  sat_counter #(
    .WIDTH(RUN_CNT_W)
  ) u_cycCounter (
    .clk    (clk),
    .rst    (rst),
    .clear_i(cntClear),
    .en_i   (cntEn),
    .count_o(cyc_count)
  );

  assign escribir   = escribir_q;
  assign dirIniciar = dir_q;
  assign EWIniciar  = ew_q;
  assign done       = done_q;

endmodule

// File: tb/tb_reg_bank_loader.sv
// Bench for reg_bank_loader: three configurations run side by side, each
// compared every cycle against a behavioural model, plus a vector table and
// hand-written load/run/stop/reset sequences.
module tb_reg_bank_loader;

  typedef struct packed {
    logic        inReady;
    logic        ew;
    logic [31:0] data;
    logic [4:0]  dir;
    logic        sel;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
  } outRec_t;

  typedef struct {
    logic        rst;
    logic        start;
    logic        stop;
    logic        valid;
    logic [31:0] data;
    outRec_t     exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst[3], start[3], stop[3], inValid[3];
  logic [31:0] inData[3];
  logic        inReady[3], ew[3], sel[3], busy[3], done[3];
  logic [31:0] escribir[3];
  logic [4:0]  dir[3];
  logic [15:0] cnt[3];

  int checks = 0;
  int errors = 0;

  // Model configuration per instance: A = full bank, 5-cycle run; B = full bank, open run; C = single register 8, 3-cycle run.
  int pFirst[3] = '{1, 1, 8};
  int pLast[3]  = '{31, 31, 8};
  int pRc[3]    = '{5, 0, 3};

  // Model state: loading / running flags, next address, run age (-1 while the last write drains).
  bit          mLoad[3], mRun[3], mEw[3], mDone[3];
  int          mAddr[3], mAge[3], mCount[3];
  logic [31:0] mData[3];
  logic [4:0]  mDir[3];

  always #5 clk = ~clk;

  reg_bank_loader #(.FIRST_REG(1), .LAST_REG(31), .RUN_CYCLES(16'd5)) dutA (
    .clk(clk), .rst(rst[0]), .start(start[0]), .stop(stop[0]), .in_valid(inValid[0]),
    .in_data(inData[0]), .in_ready(inReady[0]), .escribir(escribir[0]), .dirIniciar(dir[0]),
    .EWIniciar(ew[0]), .sel(sel[0]), .busy(busy[0]), .done(done[0]), .cyc_count(cnt[0]));

  reg_bank_loader #(.FIRST_REG(1), .LAST_REG(31), .RUN_CYCLES(16'd0)) dutB (
    .clk(clk), .rst(rst[1]), .start(start[1]), .stop(stop[1]), .in_valid(inValid[1]),
    .in_data(inData[1]), .in_ready(inReady[1]), .escribir(escribir[1]), .dirIniciar(dir[1]),
    .EWIniciar(ew[1]), .sel(sel[1]), .busy(busy[1]), .done(done[1]), .cyc_count(cnt[1]));

  reg_bank_loader #(.FIRST_REG(8), .LAST_REG(8), .RUN_CYCLES(16'd3)) dutC (
    .clk(clk), .rst(rst[2]), .start(start[2]), .stop(stop[2]), .in_valid(inValid[2]),
    .in_data(inData[2]), .in_ready(inReady[2]), .escribir(escribir[2]), .dirIniciar(dir[2]),
    .EWIniciar(ew[2]), .sel(sel[2]), .busy(busy[2]), .done(done[2]), .cyc_count(cnt[2]));

  function automatic outRec_t readOut(int d);
    return outRec_t'{inReady[d], ew[d], escribir[d], dir[d], sel[d], busy[d], done[d], cnt[d]};
  endfunction

  function automatic outRec_t modelOut(int d);
    return outRec_t'{mLoad[d], mEw[d], mData[d], mDir[d], mRun[d] && (mAge[d] >= 0),
                     mLoad[d] || mRun[d], mDone[d], 16'(mCount[d])};
  endfunction

  function automatic outRec_t mkExp(logic r, logic e, logic [31:0] dt, logic [4:0] a,
                                    logic s, logic b, logic dn, logic [15:0] c);
    return outRec_t'{r, e, dt, a, s, b, dn, c};
  endfunction

  function automatic vec_t mkVec(logic r, logic s, logic p, logic v, logic [31:0] dt, outRec_t e);
    vec_t x;
    x.rst = r; x.start = s; x.stop = p; x.valid = v; x.data = dt; x.exp = e;
    return x;
  endfunction

  // One clock of the behavioural model, using the inputs the DUT sampled on this edge.
  function automatic void modelStep(int d);
    bit nEw = 1'b0;
    bit nDone = 1'b0;
    if (rst[d]) begin
      mLoad[d] = 0; mRun[d] = 0; mEw[d] = 0; mDone[d] = 0;
      mAddr[d] = pFirst[d]; mAge[d] = 0; mCount[d] = 0; mData[d] = '0; mDir[d] = '0;
      return;
    end
    if (!mLoad[d] && !mRun[d]) begin
      if (start[d]) begin
        mLoad[d] = 1;
        mAddr[d] = pFirst[d];
      end
    end else if (mLoad[d]) begin
      if (stop[d]) begin
        mLoad[d] = 0;
      end else if (inValid[d]) begin
        nEw = 1'b1;
        mData[d] = inData[d];
        mDir[d] = 5'(mAddr[d]);
        if (mAddr[d] == pLast[d]) begin
          mLoad[d] = 0; mRun[d] = 1; mAge[d] = -1; mCount[d] = 0;
        end else begin
          mAddr[d]++;
        end
      end
    end else begin
      if (stop[d]) begin
        mRun[d] = 0;
      end else if (mAge[d] < 0) begin
        mAge[d] = 0;
      end else if ((pRc[d] != 0) && (mAge[d] == pRc[d] - 1)) begin
        mRun[d] = 0;
        nDone = 1'b1;
      end else begin
        mAge[d]++;
        if (mCount[d] < 65535) mCount[d]++;
      end
    end
    mEw[d] = nEw;
    mDone[d] = nDone;
  endfunction

  task automatic checkVal(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(int d);
    checkVal($sformatf("model dut%0d", d), 64'(readOut(d)), 64'(modelOut(d)));
  endtask

  task automatic applyStimulus(int d, logic r, logic s, logic p, logic v, logic [31:0] dt);
    rst[d] = r; start[d] = s; stop[d] = p; inValid[d] = v; inData[d] = dt;
  endtask

  task automatic clearInputs();
    for (int d = 0; d < 3; d++) applyStimulus(d, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Inputs change only after the falling edge; the model steps on the rising edge and outputs are checked at the next falling edge.
  task automatic runCycle();
    @(posedge clk);
    for (int d = 0; d < 3; d++) modelStep(d);
    @(negedge clk);
    for (int d = 0; d < 3; d++) checkOutput(d);
  endtask

  vec_t tbl[14];

  initial begin
    int pulses;
    int selCount;
    int doneCount;
    int firstSel;
    int doneAt;
    bit found;

    for (int d = 0; d < 3; d++) begin
      mLoad[d] = 0; mRun[d] = 0; mEw[d] = 0; mDone[d] = 0;
      mAddr[d] = pFirst[d]; mAge[d] = 0; mCount[d] = 0; mData[d] = '0; mDir[d] = '0;
    end

    // Reset all instances.
    clearInputs();
    for (int d = 0; d < 3; d++) rst[d] = 1'b1;
    @(negedge clk);
    runCycle();
    runCycle();
    for (int d = 0; d < 3; d++) checkVal($sformatf("reset dut%0d", d), 64'(readOut(d)), 64'd0);
    clearInputs();

    // Vector table on the single-register instance: stall, ignored starts, timed run, stops.
    tbl[0]  = mkVec(1, 0, 0, 0, 32'h0,        mkExp(0, 0, 32'h0,        5'd0, 0, 0, 0, 16'd0));
    tbl[1]  = mkVec(0, 1, 0, 0, 32'h0,        mkExp(1, 0, 32'h0,        5'd0, 0, 1, 0, 16'd0));
    tbl[2]  = mkVec(0, 0, 0, 0, 32'h0,        mkExp(1, 0, 32'h0,        5'd0, 0, 1, 0, 16'd0));
    tbl[3]  = mkVec(0, 1, 0, 1, 32'hDEADBEEF, mkExp(0, 1, 32'hDEADBEEF, 5'd8, 0, 1, 0, 16'd0));
    tbl[4]  = mkVec(0, 1, 0, 1, 32'h12345678, mkExp(0, 0, 32'hDEADBEEF, 5'd8, 1, 1, 0, 16'd0));
    tbl[5]  = mkVec(0, 1, 0, 0, 32'h0,        mkExp(0, 0, 32'hDEADBEEF, 5'd8, 1, 1, 0, 16'd1));
    tbl[6]  = mkVec(0, 0, 0, 0, 32'h0,        mkExp(0, 0, 32'hDEADBEEF, 5'd8, 1, 1, 0, 16'd2));
    tbl[7]  = mkVec(0, 1, 0, 0, 32'h0,        mkExp(0, 0, 32'hDEADBEEF, 5'd8, 0, 0, 1, 16'd2));
    tbl[8]  = mkVec(0, 0, 0, 0, 32'h0,        mkExp(0, 0, 32'hDEADBEEF, 5'd8, 0, 0, 0, 16'd2));
    tbl[9]  = mkVec(0, 1, 0, 0, 32'h0,        mkExp(1, 0, 32'hDEADBEEF, 5'd8, 0, 1, 0, 16'd2));
    tbl[10] = mkVec(0, 0, 1, 1, 32'hCAFEF00D, mkExp(0, 0, 32'hDEADBEEF, 5'd8, 0, 0, 0, 16'd2));
    tbl[11] = mkVec(0, 1, 0, 0, 32'h0,        mkExp(1, 0, 32'hDEADBEEF, 5'd8, 0, 1, 0, 16'd2));
    tbl[12] = mkVec(0, 0, 0, 1, 32'h000000AA, mkExp(0, 1, 32'h000000AA, 5'd8, 0, 1, 0, 16'd0));
    tbl[13] = mkVec(0, 0, 1, 0, 32'h0,        mkExp(0, 0, 32'h000000AA, 5'd8, 0, 0, 0, 16'd0));
    for (int i = 0; i < 14; i++) begin
      applyStimulus(2, tbl[i].rst, tbl[i].start, tbl[i].stop, tbl[i].valid, tbl[i].data);
      runCycle();
      checkVal($sformatf("vec%0d", i), 64'(readOut(2)), 64'(tbl[i].exp));
    end
    clearInputs();

    // Reset in the middle of a load, with a word on offer during reset.
    applyStimulus(0, 0, 1, 0, 0, 32'h0);
    runCycle();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, 1, 32'h200 + 32'(k));
      runCycle();
    end
    applyStimulus(0, 1, 0, 0, 1, 32'h2FF);
    runCycle();
    checkVal("midLoadReset", 64'(readOut(0)), 64'd0);
    applyStimulus(0, 0, 1, 0, 0, 32'h0);
    runCycle();
    applyStimulus(0, 0, 0, 0, 1, 32'h300);
    runCycle();
    checkVal("restartEw", 64'(ew[0]), 64'd1);
    checkVal("restartDir", 64'(dir[0]), 64'd1);
    applyStimulus(0, 0, 0, 1, 0, 32'h0);
    runCycle();
    clearInputs();

    // Full 31-word load followed by a 5-cycle run window.
    applyStimulus(0, 0, 1, 0, 0, 32'h0);
    runCycle();
    for (int a = 1; a <= 31; a++) begin
      applyStimulus(0, 0, 0, 0, 1, 32'h100 + 32'(a));
      runCycle();
      checkVal($sformatf("fullEw%0d", a), 64'(ew[0]), 64'd1);
      checkVal($sformatf("fullDir%0d", a), 64'(dir[0]), 64'(a));
      checkVal($sformatf("fullData%0d", a), 64'(escribir[0]), 64'(32'h100 + 32'(a)));
      checkVal($sformatf("fullSelLow%0d", a), 64'(sel[0]), 64'd0);
    end
    clearInputs();
    selCount = 0; doneCount = 0; firstSel = -1; doneAt = -1;
    for (int k = 0; k < 9; k++) begin
      runCycle();
      if (sel[0]) begin
        selCount++;
        if (firstSel < 0) firstSel = k;
      end
      if (done[0]) begin
        doneCount++;
        doneAt = k;
      end
    end
    checkVal("runSelCycles", 64'(selCount), 64'd5);
    checkVal("runSelFirst", 64'(firstSel), 64'd0);
    checkVal("runDoneCount", 64'(doneCount), 64'd1);
    checkVal("runDoneAt", 64'(doneAt), 64'd5);
    checkVal("runSelAfter", 64'(sel[0]), 64'd0);

    // Stalled stream: valid pattern 1,0,0,1, then a stop that coincides with a transfer.
    applyStimulus(0, 0, 1, 0, 0, 32'h0);
    runCycle();
    pulses = 0;
    applyStimulus(0, 0, 0, 0, 1, 32'hA5A5A5A5);
    runCycle();
    pulses += int'(ew[0]);
    checkVal("stallW1", 64'({ew[0], dir[0], escribir[0]}), 64'({1'b1, 5'd1, 32'hA5A5A5A5}));
    applyStimulus(0, 0, 0, 0, 0, 32'h11111111);
    runCycle();
    pulses += int'(ew[0]);
    applyStimulus(0, 0, 0, 0, 0, 32'h22222222);
    runCycle();
    pulses += int'(ew[0]);
    applyStimulus(0, 0, 0, 0, 1, 32'h5A5A5A5A);
    runCycle();
    pulses += int'(ew[0]);
    checkVal("stallW2", 64'({ew[0], dir[0], escribir[0]}), 64'({1'b1, 5'd2, 32'h5A5A5A5A}));
    checkVal("stallPulses", 64'(pulses), 64'd2);
    applyStimulus(0, 0, 0, 0, 1, 32'h33333333);
    runCycle();
    checkVal("addr3Dir", 64'(dir[0]), 64'd3);
    applyStimulus(0, 0, 0, 1, 1, 32'h44444444);
    runCycle();
    checkVal("stopXferEw", 64'(ew[0]), 64'd0);
    checkVal("stopXferReady", 64'(inReady[0]), 64'd0);
    checkVal("stopXferBusy", 64'(busy[0]), 64'd0);
    checkVal("stopXferDir", 64'(dir[0]), 64'd3);
    clearInputs();

    // Open-ended run stopped at cyc_count 7.
    applyStimulus(1, 0, 1, 0, 0, 32'h0);
    runCycle();
    for (int a = 1; a <= 31; a++) begin
      applyStimulus(1, 0, 0, 0, 1, $urandom);
      runCycle();
    end
    clearInputs();
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      runCycle();
      if (sel[1] && (cnt[1] == 16'd7)) found = 1;
    end
    checkVal("openRunReach7", 64'(found), 64'd1);
    if (found) begin
      applyStimulus(1, 0, 0, 1, 0, 32'h0);
      runCycle();
      clearInputs();
      checkVal("openStop", 64'({sel[1], done[1], busy[1], cnt[1]}), 64'({3'b000, 16'd7}));
      runCycle();
      checkVal("openHold", 64'({done[1], cnt[1]}), 64'({1'b0, 16'd7}));
    end

    // Randomised traffic on all three instances against the model.
    for (int k = 0; k < 800; k++) begin
      for (int d = 0; d < 3; d++) begin
        applyStimulus(d, $urandom_range(0, 149) == 0, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom);
      end
      runCycle();
    end
    clearInputs();
    runCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
